// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional saturation is enabled by defining SERIAL_ADDSUB_SAT_EN (see serial_addsub.sv).
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; it must hold values 0..w-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational 1-bit full adder cell: the only arithmetic in the serial datapath.
module serial_addsub_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per cycle.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and DONE holds its outputs until out_ready.
  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, shreg, res_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, ovf_q;
  logic             fa_s, fa_c, last, ovf_bit;
  logic [WIDTH-1:0] raw_res, fin_res;

  serial_addsub_fa_cell u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign raw_res = {fa_s, shreg[WIDTH-1:1]};
  // On the last bit, carry holds the carry into the MSB.
  assign ovf_bit = carry ^ fa_c;

`ifdef SERIAL_ADDSUB_SAT_EN
  // On overflow both effective operands share A's sign, which is op_a[0] now.
  assign fin_res = !ovf_bit ? raw_res :
                   op_a[0]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign fin_res = raw_res;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      shreg  <= '0;
      res_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        shreg <= raw_res;
        carry <= fa_c;
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          res_q  <= fin_res;
          cout_q <= fa_c;
          ovf_q  <= ovf_bit;
        end
      end
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an integer-arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = -1;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                output logic [W-1:0] r, output logic c, output logic o);
    int sa, sb, ua, ub, tr;
    sa = $signed(av);
    sb = $signed(bv);
    ua = int'(av);
    ub = int'(bv);
    if (sv) begin
      tr = sa - sb;
      c  = (ua >= ub);
      r  = W'(ua - ub);
    end else begin
      tr = sa + sb;
      c  = ((ua + ub) >= (1 << W));
      r  = W'(ua + ub);
    end
    o = (tr > (2 ** (W - 1)) - 1) || (tr < -(2 ** (W - 1)));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (o) r = (tr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
  endfunction

  // driver: one full operation with optional backpressure while in DONE
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input int hold, input logic chk_lat, input logic chk_gap);
    logic [W-1:0] er;
    logic         ec, eo;
    int           n;
    model(av, bv, sv, er, ec, eo);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom_range(0, 1));
    if (chk_gap && last_acc >= 0) check("accept_gap_ge_w2", (cyc - last_acc) >= W + 2, 1);
    last_acc = cyc;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (chk_lat) check("latency", n, W + 1);
    check("out_valid", out_valid, 1);
    check("result", result, er);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_cout", cout, ec);
      check("hold_ovf", ovf, eo);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("result_kept_idle", result, er);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    run_op(8'h35, 8'h4A, 1'b0, 0, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h5A, 8'h33, 1'b0, 5, 1'b0, 1'b0);

    // asynchronous reset in the middle of RUN
    a = 8'h12;
    b = 8'h34;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_result", result, 0);
    check("midrun_rst_cout", cout, 0);
    check("midrun_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_in_ready", in_ready, 1);
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b1, 1'b0);

    last_acc = -1;
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Bit-serial two's-complement adder/subtractor built around one full-adder cell and a carry flop.
- Accepts WIDTH-bit operand pairs over a valid/ready handshake.
- Processes one bit per cycle, LSB first.
- Returns sum/difference, carry-out and signed overflow over a second valid/ready handshake.
- Sequential, area-minimal alternative to the combinational ripple adders in the library; also a gate-level netlist target for sequential fault simulation.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum or difference
cout  output  1  carry-out (for sub: 1 = no borrow)
ovf  output  1  signed overflow

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, internal registers and counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch opA=a, opB=(sub ? ~b : b), carry=sub, bit counter=0; go to RUN.
- RUN:
  - in_ready=0. Each cycle the cell computes s=opA[0]^opB[0]^carry and c=majority(opA[0],opB[0],carry).
  - opA/opB shift right one bit; s shifts into the result shift register MSB; carry<=c; counter increments.
  - At counter==WIDTH-1, also capture ovf = carry_into_MSB ^ c and cout=c; go to DONE.
- DONE:
  - out_valid=1. result, cout and ovf are held stable while out_ready=0.
  - On out_ready: out_valid deasserts next cycle; go to IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle drain+accept.
- Latency: accept at edge 0; RUN occupies cycles 1..WIDTH; out_valid high from cycle WIDTH+1. Minimum throughput is one operation per WIDTH+2 cycles.
- Input rules:
  - in_valid in RUN or DONE is ignored; no input is latched.
  - a, b and sub are sampled only on the accept edge.
- Arithmetic: modulo 2^WIDTH. cout and ovf follow standard two's-complement definitions.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the in-flight operation is discarded.
- result is not cleared on return to IDLE; it holds its last value until the next DONE.

Optional Feature:
SERIAL_ADDSUB_SAT_EN
- Defined: when ovf=1, result is replaced on entry to DONE by signed saturation. The value is 0x7F..F if the true result is positive (operand signs positive), else 0x80..0. cout and ovf are reported unchanged.
- Undefined: result is the raw wrapped value. No saturation logic is present.

Decomposition:
- Package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}
  - counter-width constant/function clog2(WIDTH)
  - default WIDTH
- Sub-module serial_addsub_fa_cell: combinational 1-bit full adder (a, b, ci -> s, co), instantiated once. This keeps the carry datapath mappable to the standard-cell full-adder structure.

Test Plan (WIDTH=8):
- 0x35+0x4A, sub=0 -> result 0x7F, cout=0, ovf=0; out_valid first high exactly 9 cycles after the accept edge.
- 0xFF+0x01 -> result 0x00, cout=1, ovf=0. Then 0x7F+0x01 -> result 0x80, ovf=1 (with SAT_EN: 0x7F).
- 0x10-0x20, sub=1 -> result 0xF0, cout=0, ovf=0. Then 0x80-0x01 -> 0x7F, cout=1, ovf=1 (with SAT_EN: 0x80).
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> result/cout/ovf stable, in_ready=0, new operands not latched. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset at cycle 4 of RUN -> all outputs at reset values immediately (asynchronously). After release: in_ready=1, and the next operation 0x01+0x01 gives result 0x02.
- Back-to-back: 20 random a/b/sub triples with random out_ready -> every result matches the golden model. Accept-to-accept spacing is never below 10 cycles.
